// File: rtl/ileave_pkg.sv
// Shared types and the block permutation for the ping-pong (de)interleaver scheduler.
package ileave_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_PAD  = 2'd2,
        W_WAIT = 2'd3
    } wr_state_e;

    // Column-major readout of a row-major block; mode 1 swaps the roles of ROWS and COLS
    function automatic int perm_addr(input int k, input logic mode, input int rows, input int cols);
        if (mode == 1'b0) begin
            perm_addr = (k % rows) * cols + k / rows;
        end else begin
            perm_addr = (k % cols) * rows + k / cols;
        end
    endfunction

endpackage

// File: rtl/ileave_addr_gen.sv
// Block position counter with optional permutation; mode is captured on the first step of a block.
module ileave_addr_gen
    import ileave_pkg::*;
#(
    parameter int  ROWS = 4,
    parameter int  COLS = 4,
    parameter bit  PERM = 1'b0,
    localparam int N    = ROWS * COLS,
    localparam int AW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          i_inc,
    input  logic          i_mode,
    output logic [AW-1:0] o_addr,
    output logic          o_wrap
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    logic [AW-1:0] r_cnt;
    logic          r_mode;
    logic [AW-1:0] w_perm;

    // Position counter and per-block mode capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= {AW{1'b0}};
            r_mode <= 1'b0;
        end else if (clr) begin
            r_cnt  <= {AW{1'b0}};
            r_mode <= 1'b0;
        end else if (i_inc) begin
            r_cnt <= (r_cnt == LAST_IDX) ? {AW{1'b0}} : r_cnt + AW'(1'b1);
            if (r_cnt == {AW{1'b0}}) begin
                r_mode <= i_mode;
            end else begin
                r_mode <= r_mode;
            end
        end else begin
            r_cnt  <= r_cnt;
            r_mode <= r_mode;
        end
    end

    // k = 0 maps to address 0 in either mode, so the captured mode is already valid for k >= 1
    assign w_perm = AW'(perm_addr(int'(r_cnt), r_mode, ROWS, COLS));
    assign o_addr = PERM ? w_perm : r_cnt;
    assign o_wrap = (r_cnt == LAST_IDX);

endmodule

// File: rtl/ileave_bank_scheduler.sv
// Two-bank ping-pong scheduler: linear writes into the free bank, permuted reads from the oldest full bank.
// End-of-packet zero padding and out_last are built only when ILV_FLUSH_EN is defined.
module ileave_bank_scheduler
    import ileave_pkg::*;
#(
    parameter int  ROWS = 4,
    parameter int  COLS = 4,
    localparam int N    = ROWS * COLS,
    localparam int AW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          mode,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          wr_zero,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    input  logic          out_ready,
    output logic          out_valid,
    output logic          out_last,
    output logic          busy
);

`ifdef ILV_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    wr_state_e   r_wr_state, w_wr_state_nxt;
    bank_state_e r_bank_st [2];
    bank_state_e w_bank_st_nxt [2];
    logic [1:0]  r_last, w_last_nxt;
    logic        r_wr_bank, r_rd_bank, r_out_valid, r_out_last;

    logic          w_in_ready, w_accept, w_pad_wr, w_wr_en;
    logic          w_wr_done, w_set_last;
    logic          w_rd_avail, w_rd_en, w_rd_release;
    logic          w_wcnt_wrap, w_rcnt_wrap, w_other_free, w_cur_free;
    logic [AW-1:0] w_wr_addr, w_rd_addr;

    ileave_addr_gen #(.ROWS(ROWS), .COLS(COLS), .PERM(1'b0)) u_wr_gen (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .i_inc  (w_wr_en),
        .i_mode (1'b0),
        .o_addr (w_wr_addr),
        .o_wrap (w_wcnt_wrap)
    );

    ileave_addr_gen #(.ROWS(ROWS), .COLS(COLS), .PERM(1'b1)) u_rd_gen (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .i_inc  (w_rd_en),
        .i_mode (mode),
        .o_addr (w_rd_addr),
        .o_wrap (w_rcnt_wrap)
    );

    // Strobes are gated by rst/clr so every output is quiet while either is held
    assign w_in_ready   = rst & ~clr & ((r_wr_state == W_IDLE) | (r_wr_state == W_FILL));
    assign w_accept     = in_valid & w_in_ready;
    assign w_pad_wr     = rst & ~clr & (r_wr_state == W_PAD);
    assign w_wr_en      = w_accept | w_pad_wr;
    assign w_rd_avail   = (r_bank_st[r_rd_bank] == FULL) | (r_bank_st[r_rd_bank] == DRAINING);
    assign w_rd_en      = rst & ~clr & out_ready & w_rd_avail;
    assign w_rd_release = w_rd_en & w_rcnt_wrap;
    assign w_other_free = (r_bank_st[~r_wr_bank] == EMPTY) | (w_rd_release & (r_rd_bank != r_wr_bank));
    assign w_cur_free   = (r_bank_st[r_wr_bank] == EMPTY) | (w_rd_release & (r_rd_bank == r_wr_bank));

    // Writer next state: fill, optional zero padding, wait for the next bank to drain
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_done      = 1'b0;
        w_set_last     = 1'b0;
        case (r_wr_state)
            W_IDLE, W_FILL: begin
                if (w_accept && w_wcnt_wrap) begin
                    w_wr_done      = 1'b1;
                    w_set_last     = FLUSH_EN & in_last;
                    w_wr_state_nxt = w_other_free ? W_IDLE : W_WAIT;
                end else if (w_accept && FLUSH_EN && in_last) begin
                    w_wr_state_nxt = W_PAD;
                end else if (w_accept) begin
                    w_wr_state_nxt = W_FILL;
                end else begin
                    w_wr_state_nxt = r_wr_state;
                end
            end
            W_PAD: begin
                if (w_pad_wr && w_wcnt_wrap) begin
                    w_wr_done      = 1'b1;
                    w_set_last     = 1'b1;
                    w_wr_state_nxt = w_other_free ? W_IDLE : W_WAIT;
                end else begin
                    w_wr_state_nxt = W_PAD;
                end
            end
            W_WAIT: begin
                if (w_cur_free) begin
                    w_wr_state_nxt = W_IDLE;
                end else begin
                    w_wr_state_nxt = W_WAIT;
                end
            end
            default: begin
                w_wr_state_nxt = W_IDLE;
            end
        endcase
    end

    // Per-bank lifecycle; writer and reader never touch the same bank in one cycle
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bank_st_nxt[b] = r_bank_st[b];
            w_last_nxt[b]    = r_last[b];
            if (w_wr_en && (r_wr_bank == 1'(b))) begin
                if (w_wr_done) begin
                    w_bank_st_nxt[b] = FULL;
                    w_last_nxt[b]    = w_set_last;
                end else if (r_bank_st[b] == EMPTY) begin
                    w_bank_st_nxt[b] = FILLING;
                end else begin
                    w_bank_st_nxt[b] = r_bank_st[b];
                end
            end else if (w_rd_en && (r_rd_bank == 1'(b))) begin
                if (w_rcnt_wrap) begin
                    w_bank_st_nxt[b] = EMPTY;
                    w_last_nxt[b]    = 1'b0;
                end else begin
                    w_bank_st_nxt[b] = DRAINING;
                end
            end else begin
                w_bank_st_nxt[b] = r_bank_st[b];
            end
        end
    end

    // State, bank pointers and the one-cycle read-data qualifiers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_state   <= W_IDLE;
            r_bank_st[0] <= EMPTY;
            r_bank_st[1] <= EMPTY;
            r_last       <= 2'b00;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else if (clr) begin
            r_wr_state   <= W_IDLE;
            r_bank_st[0] <= EMPTY;
            r_bank_st[1] <= EMPTY;
            r_last       <= 2'b00;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_wr_state   <= w_wr_state_nxt;
            r_bank_st[0] <= w_bank_st_nxt[0];
            r_bank_st[1] <= w_bank_st_nxt[1];
            r_last       <= w_last_nxt;
            r_wr_bank    <= r_wr_bank ^ w_wr_done;
            r_rd_bank    <= r_rd_bank ^ w_rd_release;
            r_out_valid  <= w_rd_en;
            r_out_last   <= w_rd_release & r_last[r_rd_bank];
        end
    end

    assign in_ready  = w_in_ready;
    assign wr_en     = w_wr_en;
    assign wr_bank   = r_wr_bank;
    assign wr_addr   = w_wr_addr;
    assign wr_zero   = w_pad_wr;
    assign rd_en     = w_rd_en;
    assign rd_bank   = r_rd_bank;
    assign rd_addr   = w_rd_addr;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_bank_st[0] != EMPTY) | (r_bank_st[1] != EMPTY) | (r_wr_state == W_PAD);

endmodule

// File: tb/tb_ileave_bank_scheduler.sv
// Directed bench for ileave_bank_scheduler: a 4x4 instance and a 2x8 instance share clk/rst.
module tb_ileave_bank_scheduler;

`ifdef ILV_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_clr, a_mode, a_in_valid, a_in_last, a_in_ready, a_wr_en, a_wr_bank, a_wr_zero;
    logic       a_rd_en, a_rd_bank, a_out_ready, a_out_valid, a_out_last, a_busy;
    logic [3:0] a_wr_addr, a_rd_addr;
    logic       b_clr, b_mode, b_in_valid, b_in_last, b_in_ready, b_wr_en, b_wr_bank, b_wr_zero;
    logic       b_rd_en, b_rd_bank, b_out_ready, b_out_valid, b_out_last, b_busy;
    logic [3:0] b_wr_addr, b_rd_addr;

    int tests = 0;
    int fails = 0;
    int tbl_a  [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int tbl_m1 [16] = '{0, 2, 4, 6, 8, 10, 12, 14, 1, 3, 5, 7, 9, 11, 13, 15};
    int tbl_m0 [16] = '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15};

    ileave_bank_scheduler #(.ROWS(4), .COLS(4)) u_dut_a (
        .clk(clk), .rst(rst), .clr(a_clr), .mode(a_mode),
        .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
        .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_addr(a_wr_addr), .wr_zero(a_wr_zero),
        .rd_en(a_rd_en), .rd_bank(a_rd_bank), .rd_addr(a_rd_addr),
        .out_ready(a_out_ready), .out_valid(a_out_valid), .out_last(a_out_last), .busy(a_busy)
    );

    ileave_bank_scheduler #(.ROWS(2), .COLS(8)) u_dut_b (
        .clk(clk), .rst(rst), .clr(b_clr), .mode(b_mode),
        .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
        .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_addr(b_wr_addr), .wr_zero(b_wr_zero),
        .rd_en(b_rd_en), .rd_bank(b_rd_bank), .rd_addr(b_rd_addr),
        .out_ready(b_out_ready), .out_valid(b_out_valid), .out_last(b_out_last), .busy(b_busy)
    );

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        a_clr = 1'b0; a_mode = 1'b0; a_in_valid = 1'b1; a_in_last = 1'b0; a_out_ready = 1'b1;
        b_clr = 1'b0; b_mode = 1'b0; b_in_valid = 1'b1; b_in_last = 1'b0; b_out_ready = 1'b1;

        // Reset held: every output low even with in_valid/out_ready offered
        @(negedge clk); #1;
        chk("rst.a_outs", 0, {a_in_ready, a_wr_en, a_wr_bank, a_wr_addr, a_wr_zero, a_rd_en,
                              a_rd_bank, a_rd_addr, a_out_valid, a_out_last, a_busy}, 0);
        chk("rst.b_outs", 0, {b_in_ready, b_wr_en, b_wr_bank, b_wr_addr, b_wr_zero, b_rd_en,
                              b_rd_bank, b_rd_addr, b_out_valid, b_out_last, b_busy}, 0);
        @(negedge clk);
        rst = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
        #1;
        chk("rst.in_ready", 0, a_in_ready, 1);
        chk("rst.wr_bank", 0, a_wr_bank, 0);
        chk("rst.busy", 0, a_busy, 0);

        // 32 continuous bits, mode 0, sink always ready
        for (int c = 0; c < 51; c++) begin
            @(negedge clk);
            a_in_valid = (c < 32); a_out_ready = 1'b1; a_mode = 1'b0;
            #1;
            chk("A.in_ready", c, a_in_ready, 1);
            chk("A.wr_en", c, a_wr_en, (c < 32));
            if (c < 32) begin
                chk("A.wr_bank", c, a_wr_bank, c / 16);
                chk("A.wr_addr", c, a_wr_addr, c % 16);
            end
            chk("A.rd_en", c, a_rd_en, (c >= 16 && c < 48));
            if (c >= 16 && c < 48) begin
                chk("A.rd_bank", c, a_rd_bank, (c - 16) / 16);
                chk("A.rd_addr", c, a_rd_addr, tbl_a[(c - 16) % 16]);
            end
            chk("A.out_valid", c, a_out_valid, (c >= 17 && c < 49));
            chk("A.out_last", c, a_out_last, 0);
        end
        chk("A.busy_end", 51, a_busy, 0);

        // Reset in the middle of a partial block discards it
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            #1;
            chk("R.wr_addr", c, a_wr_addr, c);
        end
        chk("R.busy_pre", 5, a_busy, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("R.a_outs", 6, {a_in_ready, a_wr_en, a_wr_bank, a_wr_addr, a_wr_zero, a_rd_en,
                            a_rd_bank, a_rd_addr, a_out_valid, a_out_last, a_busy}, 0);
        @(negedge clk);
        rst = 1'b1; a_in_valid = 1'b0;
        #1;
        chk("R.in_ready", 7, a_in_ready, 1);
        chk("R.wr_bank", 7, a_wr_bank, 0);
        chk("R.wr_addr", 7, a_wr_addr, 0);
        chk("R.busy", 7, a_busy, 0);

        // Both banks full under backpressure; writes resume one cycle after bank 0 drains
        for (int c = 0; c < 61; c++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_out_ready = (c >= 40);
            #1;
            chk("B.in_ready", c, a_in_ready, (c < 32) || (c >= 56));
            chk("B.wr_en", c, a_wr_en, (c < 32) || (c >= 56));
            if (c < 32) begin
                chk("B.wr_addr", c, a_wr_addr, c % 16);
            end
            if (c >= 56) begin
                chk("B.wr_bank_resume", c, a_wr_bank, 0);
                chk("B.wr_addr_resume", c, a_wr_addr, c - 56);
            end
            chk("B.rd_en", c, a_rd_en, (c >= 40));
            if (c >= 40) begin
                chk("B.rd_bank", c, a_rd_bank, (c >= 56));
                chk("B.rd_addr", c, a_rd_addr, tbl_a[(c < 56) ? (c - 40) : (c - 56)]);
            end
            chk("B.out_valid", c, a_out_valid, (c >= 41));
        end

        // Synchronous clear mid-stream
        @(negedge clk);
        a_clr = 1'b1; a_in_valid = 1'b0;
        #1;
        chk("C.clr_in_ready", 0, a_in_ready, 0);
        chk("C.clr_rd_en", 0, a_rd_en, 0);
        @(negedge clk);
        a_clr = 1'b0;
        #1;
        chk("C.busy", 1, a_busy, 0);
        chk("C.wr_bank", 1, a_wr_bank, 0);
        chk("C.rd_bank", 1, a_rd_bank, 0);
        chk("C.in_ready", 1, a_in_ready, 1);
        chk("C.wr_addr", 1, a_wr_addr, 0);
        chk("C.out_valid", 1, a_out_valid, 0);

        // 2x8 instance: mode 1 block, mode dropped mid-block takes effect on the next block only
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            b_in_valid = (c < 32); b_out_ready = 1'b1; b_mode = (c < 20);
            #1;
            chk("M.in_ready", c, b_in_ready, 1);
            if (c < 32) begin
                chk("M.wr_addr", c, b_wr_addr, c % 16);
                chk("M.wr_bank", c, b_wr_bank, c / 16);
            end
            chk("M.rd_en", c, b_rd_en, (c >= 16 && c < 48));
            if (c >= 16 && c < 48) begin
                chk("M.rd_addr", c, b_rd_addr, (c < 32) ? tbl_m1[c - 16] : tbl_m0[c - 32]);
            end
            chk("M.out_valid", c, b_out_valid, (c >= 17 && c < 49));
        end

        // in_last on the 6th bit: zero padding when flush is built, ignored otherwise
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            a_in_valid = FLUSH ? (c < 6) : (c < 16);
            a_in_last = (c == 5); a_out_ready = 1'b1; a_mode = 1'b0;
            #1;
            chk("F.in_ready", c, a_in_ready, !(FLUSH && c >= 6 && c < 16));
            chk("F.wr_en", c, a_wr_en, (c < 16));
            chk("F.wr_zero", c, a_wr_zero, (FLUSH && c >= 6 && c < 16));
            if (c < 16) begin
                chk("F.wr_addr", c, a_wr_addr, c);
                chk("F.wr_bank", c, a_wr_bank, 0);
                chk("F.busy", c, a_busy, (c > 0));
            end
            chk("F.rd_en", c, a_rd_en, (c >= 16 && c < 32));
            if (c >= 16 && c < 32) begin
                chk("F.rd_addr", c, a_rd_addr, tbl_a[c - 16]);
            end
            chk("F.out_valid", c, a_out_valid, (c >= 17 && c < 33));
            chk("F.out_last", c, a_out_last, (FLUSH && c == 32));
        end
        chk("F.busy_end", 35, a_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
